tx_pattern_gen: RTL and testbench

TX_PATTERN_GEN -- requirements
Module: tx_pattern_gen

---
 rtl/tx_pattern_gen_pkg.sv | 21 ++
 rtl/tx_pattern_gen_err_inject.sv | 34 +++
 rtl/tx_pattern_gen.sv | 138 +++++++++++++
 tb/tb_tx_pattern_gen.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/tx_pattern_gen_pkg.sv
// tx_pattern_gen_pkg: command bytes, test pattern and state encoding shared
// by the pattern transmitter and the far-end receiver.
package tx_pattern_gen_pkg;

    localparam logic [7:0] CMD_START = 8'h53;
    localparam logic [7:0] CMD_ABORT = 8'h58;
    localparam logic [7:0] PATTERN   = 8'hAA;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        TAIL
    } tx_state_e;

    // Pattern is sent MSB first, so index 0 selects bit 7.
    function automatic logic pattern_bit(input logic [2:0] idx);
        return PATTERN[3'd7 - idx];
    endfunction

endpackage

// File: rtl/tx_pattern_gen_err_inject.sv
// tx_err_inject: counts emitted pattern bits and inverts every ERR_PERIOD-th.
// Only built when TX_ERR_INJECT_EN is defined.
`ifdef TX_ERR_INJECT_EN
module tx_err_inject #(
    parameter int unsigned ERR_PERIOD = 1000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic adv_i,
    input  logic bit_i,
    output logic bit_o,
    output logic hit_o
);

    localparam logic [31:0] LAST = 32'(ERR_PERIOD - 1);

    logic [31:0] per_q;

    assign hit_o = adv_i && (per_q == LAST);
    assign bit_o = bit_i ^ hit_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            per_q <= '0;
        end else if (clear_i) begin
            per_q <= '0;
        end else if (adv_i) begin
            per_q <= hit_o ? '0 : per_q + 32'd1;
        end
    end

endmodule
`endif

// File: rtl/tx_pattern_gen.sv
// tx_pattern_gen: BER transmitter -- alternating preamble, 8'hAA pattern, low tail.
// Define TX_ERR_INJECT_EN to invert every ERR_PERIOD-th pattern bit.
module tx_pattern_gen
    import tx_pattern_gen_pkg::*;
#(
    parameter int unsigned PREAMBLE_BITS = 32,
    parameter int unsigned MAX_BITS      = 32'h4C4B400,
    parameter int unsigned TAIL_BITS     = 256,
    parameter int unsigned ERR_PERIOD    = 1000
) (
    input  logic        clk_der,
    input  logic        rst,
    input  logic        from_uart_valid,
    input  logic [7:0]  from_uart_data,
    output logic        tx_bit_data,
    output logic        tx_active,
    output logic        tx_done,
    output logic [31:0] tx_bit_count,
    output logic [31:0] err_inj_count
);

    tx_state_e   state_q;
    logic [31:0] cnt_q;
    logic [31:0] bits_q;
    logic [31:0] errs_q;
    logic        bit_q;
    logic        active_q;
    logic        done_q;

    logic is_start;
    logic is_abort;
    logic data_step;
    logic pat_bit;
    logic out_bit;
    logic hit;

    assign is_start = from_uart_valid && (from_uart_data == CMD_START);
    assign is_abort = from_uart_valid && (from_uart_data == CMD_ABORT);
    assign pat_bit  = pattern_bit(bits_q[2:0]);

    // A pattern bit goes out on the last preamble edge and on every DATA
    // edge until the run completes; an abort always wins.
    assign data_step = !is_abort && (
        (state_q == PREAMBLE && cnt_q == PREAMBLE_BITS) ||
        (state_q == DATA && bits_q != MAX_BITS));

`ifdef TX_ERR_INJECT_EN
    tx_err_inject #(
        .ERR_PERIOD(ERR_PERIOD)
    ) u_err_inject (
        .clk_i  (clk_der),
        .rst_i  (rst),
        .clear_i(state_q == IDLE && is_start),
        .adv_i  (data_step),
        .bit_i  (pat_bit),
        .bit_o  (out_bit),
        .hit_o  (hit)
    );
`else
    logic unused_err_period;

    assign unused_err_period = ^32'(ERR_PERIOD);
    assign out_bit = pat_bit;
    assign hit     = 1'b0;
`endif

    always_ff @(posedge clk_der or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bits_q   <= '0;
            errs_q   <= '0;
            bit_q    <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (is_start) begin
                        state_q  <= PREAMBLE;
                        cnt_q    <= 32'd1;
                        bits_q   <= '0;
                        errs_q   <= '0;
                        bit_q    <= 1'b1;
                        active_q <= 1'b1;
                    end
                end
                PREAMBLE: begin
                    if (is_abort) begin
                        state_q <= TAIL;
                        cnt_q   <= 32'd1;
                        bit_q   <= 1'b0;
                    end else if (data_step) begin
                        state_q <= DATA;
                        bits_q  <= bits_q + 32'd1;
                        bit_q   <= out_bit;
                        errs_q  <= errs_q + {31'd0, hit};
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                        bit_q <= ~cnt_q[0];
                    end
                end
                DATA: begin
                    if (data_step) begin
                        bits_q <= bits_q + 32'd1;
                        bit_q  <= out_bit;
                        errs_q <= errs_q + {31'd0, hit};
                    end else begin
                        state_q <= TAIL;
                        cnt_q   <= 32'd1;
                        bit_q   <= 1'b0;
                    end
                end
                TAIL: begin
                    if (cnt_q == TAIL_BITS) begin
                        state_q  <= IDLE;
                        cnt_q    <= '0;
                        active_q <= 1'b0;
                        done_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx_bit_data   = bit_q;
    assign tx_active     = active_q;
    assign tx_done       = done_q;
    assign tx_bit_count  = bits_q;
    assign err_inj_count = errs_q;

endmodule

// File: tb/tb_tx_pattern_gen.sv
// tb_tx_pattern_gen: randomized directed runs checked cycle by cycle against
// an expected-trace model built from the stream rules.
module tb_tx_pattern_gen;
    import tx_pattern_gen_pkg::*;

    localparam int PRE   = 16;
    localparam int MAXB  = 64;
    localparam int TAILN = 8;
    localparam int ERRP  = 10;
`ifdef TX_ERR_INJECT_EN
    localparam bit INJ = 1'b1;
`else
    localparam bit INJ = 1'b0;
`endif

    logic        clk_der = 1'b0;
    logic        rst = 1'b1;
    logic        from_uart_valid = 1'b0;
    logic [7:0]  from_uart_data = 8'h00;
    logic        tx_bit_data;
    logic        tx_active;
    logic        tx_done;
    logic [31:0] tx_bit_count;
    logic [31:0] err_inj_count;

    int n_pass = 0;
    int n_tot  = 0;
    logic [31:0] last_cnt = 0;
    logic [31:0] last_err = 0;

    typedef struct packed {
        logic        b;
        logic        act;
        logic        done;
        logic [31:0] cnt;
        logic [31:0] errs;
    } exp_t;

    exp_t q[$];

    tx_pattern_gen #(
        .PREAMBLE_BITS(PRE),
        .MAX_BITS     (MAXB),
        .TAIL_BITS    (TAILN),
        .ERR_PERIOD   (ERRP)
    ) dut (
        .clk_der        (clk_der),
        .rst            (rst),
        .from_uart_valid(from_uart_valid),
        .from_uart_data (from_uart_data),
        .tx_bit_data    (tx_bit_data),
        .tx_active      (tx_active),
        .tx_done        (tx_done),
        .tx_bit_count   (tx_bit_count),
        .err_inj_count  (err_inj_count)
    );

    always #5 clk_der = ~clk_der;

    task automatic step();
        @(posedge clk_der);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d);
        from_uart_valid = v;
        from_uart_data  = d;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_exp(input string tag, input exp_t e);
        chk({tag, ".bit"},    32'(tx_bit_data), 32'(e.b));
        chk({tag, ".active"}, 32'(tx_active),   32'(e.act));
        chk({tag, ".done"},   32'(tx_done),     32'(e.done));
        chk({tag, ".count"},  tx_bit_count,     e.cnt);
        chk({tag, ".errs"},   err_inj_count,    e.errs);
    endtask

    // Mid-run noise: 'S' and other bytes are legal, 'X' is not.
    task automatic mid_noise();
        logic [7:0] r;
        r = 8'($urandom);
        if ($urandom_range(2) == 0) r = CMD_START;
        if (r == CMD_ABORT) r = 8'h41;
        drive(1'($urandom_range(1)), r);
    endtask

    task automatic tail_noise();
        logic [7:0] r;
        r = 8'($urandom);
        if ($urandom_range(2) == 0) r = CMD_ABORT;
        drive(1'($urandom_range(1)), r);
    endtask

    task automatic idle_noise();
        logic [7:0] r;
        r = 8'($urandom);
        if ($urandom_range(2) == 0) r = CMD_ABORT;
        if ($urandom_range(2) == 0) r = 8'h41;
        if (r == CMD_START) r = 8'h41;
        drive(1'($urandom_range(1)), r);
    endtask

    // Expected trace from the cycle after the accepted 'S' to the done cycle.
    task automatic build(input int pre_n, input int pat_n);
        logic [7:0] pat;
        logic       b;
        int         e;
        exp_t       x;
        pat = 8'hAA;
        e = 0;
        q.delete();
        for (int k = 0; k < pre_n; k++) begin
            x = '{b: (k % 2 == 0), act: 1'b1, done: 1'b0, cnt: 32'd0, errs: 32'd0};
            q.push_back(x);
        end
        for (int j = 0; j < pat_n; j++) begin
            b = pat[7 - (j % 8)];
            if (INJ && ((j + 1) % ERRP == 0)) begin
                b = ~b;
                e++;
            end
            x = '{b: b, act: 1'b1, done: 1'b0, cnt: 32'(j + 1), errs: 32'(e)};
            q.push_back(x);
        end
        for (int k = 0; k < TAILN; k++) begin
            x = '{b: 1'b0, act: 1'b1, done: 1'b0, cnt: 32'(pat_n), errs: 32'(e)};
            q.push_back(x);
        end
        x = '{b: 1'b0, act: 1'b0, done: 1'b1, cnt: 32'(pat_n), errs: 32'(e)};
        q.push_back(x);
        last_cnt = 32'(pat_n);
        last_err = 32'(e);
    endtask

    task automatic start();
        drive(1'b1, CMD_START);
        step();
        drive(1'b0, 8'h00);
    endtask

    task automatic run(input int pre_n, input int pat_n, input string tag);
        int abort_t;
        build(pre_n, pat_n);
        abort_t = (pre_n < PRE || pat_n < MAXB) ? pre_n + pat_n - 1 : -1;
        start();
        for (int t = 0; t < q.size(); t++) begin
            chk_exp($sformatf("%s[%0d]", tag, t), q[t]);
            if (t == abort_t) drive(1'b1, CMD_ABORT);
            else if (t == q.size() - 1) idle_noise();
            else if (t >= pre_n + pat_n) tail_noise();
            else mid_noise();
            step();
        end
        drive(1'b0, 8'h00);
    endtask

    task automatic idle_gap(input int n, input string tag);
        exp_t x;
        x = '{b: 1'b0, act: 1'b0, done: 1'b0, cnt: last_cnt, errs: last_err};
        for (int i = 0; i < n; i++) begin
            chk_exp($sformatf("%s[%0d]", tag, i), x);
            idle_noise();
            step();
        end
        drive(1'b0, 8'h00);
    endtask

    task automatic reset_mid_run();
        exp_t z;
        int   cut;
        z = '{b: 1'b0, act: 1'b0, done: 1'b0, cnt: 32'd0, errs: 32'd0};
        build(PRE, MAXB);
        cut = PRE + $urandom_range(5, 50);
        start();
        for (int t = 0; t < cut; t++) begin
            chk_exp($sformatf("prerst[%0d]", t), q[t]);
            mid_noise();
            step();
        end
        drive(1'b0, 8'h00);
        #2 rst = 1'b1;
        #1 chk_exp("rst_async", z);
        last_cnt = 0;
        last_err = 0;
        #2 rst = 1'b0;
        idle_gap(4, "postrst");
    endtask

    initial begin
        exp_t z;
        z = '{b: 1'b0, act: 1'b0, done: 1'b0, cnt: 32'd0, errs: 32'd0};
        repeat (2) @(posedge clk_der);
        #1 chk_exp("reset", z);
        rst = 1'b0;
        idle_gap(3, "idle0");

        run(PRE, MAXB, "full");
        idle_gap(3, "idle1");

        run(PRE, 20, "abort20");
        idle_gap(2, "idle2");

        for (int i = 0; i < 3; i++) begin
            run(PRE, $urandom_range(1, MAXB - 1), $sformatf("rabort%0d", i));
            idle_gap($urandom_range(1, 4), $sformatf("ridle%0d", i));
        end

        run($urandom_range(1, PRE), 0, "preabort");
        idle_gap(2, "idle3");

        reset_mid_run();
        run(PRE, MAXB, "restart");
        idle_gap(2, "idle4");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
